// File: rtl/alu_slice_sequencer_if.sv
// Request/response bundle between the ALU front end, the slice sequencer and writeback.
// master = front end / writeback side, slave = sequencer side.
`timescale 1ns/1ps
interface alu_slice_sequencer_if #(
  parameter int unsigned DATA_W = 128
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        opsel;
  logic              mode;
  logic              cin;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] result;
  logic              c_flag;
  logic              z_flag;
  logic              s_flag;
  logic              o_flag;

  modport master (
    output req_valid, opsel, mode, cin, a, b, rsp_ready,
    input  req_ready, rsp_valid, result, c_flag, z_flag, s_flag, o_flag
  );

  modport slave (
    input  req_valid, opsel, mode, cin, a, b, rsp_ready,
    output req_ready, rsp_valid, result, c_flag, z_flag, s_flag, o_flag
  );
endinterface

// File: rtl/alu_slice_sequencer.sv
// Multi-cycle DATA_W ALU op run as LSB-first SLICE_W beats with carry ripple and c/z/s/o flags.
// Optional ALU_SEQ_BACK2BACK_EN: accept the next request in DONE when the response is taken.
`timescale 1ns/1ps
module alu_slice_sequencer #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned SLICE_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  alu_slice_sequencer_if.slave bus
);
  localparam int unsigned NBEAT  = DATA_W / SLICE_W;
  localparam int unsigned BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  if ((DATA_W % SLICE_W) != 0) begin : g_bad_width
    $error("DATA_W must be an integer multiple of SLICE_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [BEAT_W-1:0]   r_beat;
  logic [2:0]          r_op;
  logic                r_mode;
  logic                r_cin;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_res;
  logic                r_carry;
  logic                r_c, r_z, r_s, r_o;

  logic                w_req_ready;
  logic                w_accept;
  logic                w_last;
  logic [SLICE_W-1:0]  w_sa, w_sb, w_bs, w_slice;
  logic [SLICE_W:0]    w_sum;
  logic                w_cfirst, w_cin_eff, w_cout;
  logic                w_arith, w_ovf_op;
  logic [DATA_W-1:0]   w_full;

  assign w_sa      = r_a[SLICE_W-1:0];
  assign w_sb      = r_b[SLICE_W-1:0];
  assign w_last    = (r_beat == BEAT_W'(NBEAT - 1));
  assign w_accept  = bus.req_valid && w_req_ready;
  assign w_arith   = !r_mode && (r_op != 3'd7);
  assign w_ovf_op  = !r_mode && (r_op < 3'd6);
  assign w_cin_eff = (r_beat == '0) ? w_cfirst : r_carry;
  assign w_sum     = {1'b0, w_sa} + {1'b0, w_bs} + {{SLICE_W{1'b0}}, w_cin_eff};

  // Result fills from the top and shifts down, so after the last beat slice 0 sits at the LSB.
  if (NBEAT > 1) begin : g_multi
    assign w_full = {w_slice, r_res[DATA_W-1:SLICE_W]};
  end else begin : g_single
    assign w_full = w_slice;
  end

  always_comb begin
    w_bs     = '0;
    w_cfirst = 1'b0;
    case (r_op)
      3'd0: begin w_bs = w_sb;  w_cfirst = 1'b0;  end
      3'd1: begin w_bs = w_sb;  w_cfirst = r_cin; end
      3'd2: begin w_bs = ~w_sb; w_cfirst = 1'b1;  end
      3'd3: begin w_bs = ~w_sb; w_cfirst = r_cin; end
      3'd4: begin w_bs = '0;    w_cfirst = 1'b1;  end
      3'd5: begin w_bs = '1;    w_cfirst = 1'b0;  end
      default: begin w_bs = '0; w_cfirst = 1'b0;  end
    endcase
  end

  always_comb begin
    w_slice = '0;
    w_cout  = 1'b0;
    if (!r_mode) begin
      if (r_op == 3'd7) begin
        w_slice = w_sb;
      end else begin
        w_slice = w_sum[SLICE_W-1:0];
        w_cout  = w_sum[SLICE_W];
      end
    end else begin
      case (r_op)
        3'd0:    w_slice = w_sa & w_sb;
        3'd1:    w_slice = w_sa | w_sb;
        3'd2:    w_slice = w_sa ^ w_sb;
        3'd3:    w_slice = ~w_sa;
        3'd4:    w_slice = ~(w_sa & w_sb);
        3'd5:    w_slice = ~(w_sa | w_sb);
        3'd6:    w_slice = ~(w_sa ^ w_sb);
        default: w_slice = w_sa;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          w_next = S_IDLE;
`ifdef ALU_SEQ_BACK2BACK_EN
          w_req_ready = 1'b1;
          if (bus.req_valid) w_next = S_RUN;
`endif
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_op    <= '0;
      r_mode  <= 1'b0;
      r_cin   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_s     <= 1'b0;
      r_o     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= bus.opsel;
        r_mode <= bus.mode;
        r_cin  <= bus.cin;
        r_a    <= bus.a;
        r_b    <= bus.b;
        r_beat <= '0;
      end else if (r_state == S_RUN) begin
        r_a     <= r_a >> SLICE_W;
        r_b     <= r_b >> SLICE_W;
        r_res   <= w_full;
        r_carry <= w_cout;
        r_beat  <= r_beat + 1'b1;
        if (w_last) begin
          r_c <= w_arith & w_cout;
          r_z <= (w_full == '0);
          r_s <= w_full[DATA_W-1];
          r_o <= w_ovf_op && (w_sa[SLICE_W-1] == w_bs[SLICE_W-1])
                          && (w_slice[SLICE_W-1] != w_sa[SLICE_W-1]);
        end
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (r_state == S_DONE);
  assign bus.result    = r_res;
  assign bus.c_flag    = r_c;
  assign bus.z_flag    = r_z;
  assign bus.s_flag    = r_s;
  assign bus.o_flag    = r_o;
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Directed self-checking bench for alu_slice_sequencer (128-bit, 32-bit slices).
`timescale 1ns/1ps
module tb_alu_slice_sequencer;
  localparam int unsigned DATA_W = 128;
  localparam logic [DATA_W-1:0] ONES  = '1;
  localparam logic [DATA_W-1:0] MSB   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAXP  = {1'b0, {(DATA_W-1){1'b1}}};

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_slice_sequencer_if #(.DATA_W(DATA_W)) bus ();

  alu_slice_sequencer #(.DATA_W(DATA_W), .SLICE_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] flags();
    return DATA_W'({bus.c_flag, bus.z_flag, bus.s_flag, bus.o_flag});
  endfunction

  // Issue one request, scramble inputs after acceptance, check latency/result/flags.
  task automatic run_op(input string tag, input logic m, input logic [2:0] op, input logic ci,
                        input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv,
                        input logic [DATA_W-1:0] exp_r, input logic [3:0] exp_f,
                        input bit release_rsp);
    int lat;
    bus.mode = m; bus.opsel = op; bus.cin = ci; bus.a = av; bus.b = bv;
    bus.req_valid = 1'b1;
    tick;
    chk({tag, "/busy"}, DATA_W'(bus.req_ready), '0);
    bus.req_valid = 1'b0;
    bus.mode = ~m; bus.opsel = ~op; bus.cin = ~ci; bus.a = ~av; bus.b = av ^ bv ^ 128'h5;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk({tag, "/latency"}, DATA_W'(lat), DATA_W'(4));
    chk({tag, "/result"}, bus.result, exp_r);
    chk({tag, "/flags"}, flags(), DATA_W'(exp_f));
    if (release_rsp) begin
      bus.rsp_ready = 1'b1;
      tick;
      bus.rsp_ready = 1'b0;
      chk({tag, "/drop"}, DATA_W'({bus.rsp_valid, bus.req_ready}), DATA_W'(2'b01));
    end
  endtask

  initial begin
    int cnt;
    int per_exp;
`ifdef ALU_SEQ_BACK2BACK_EN
    per_exp = 5;
`else
    per_exp = 6;
`endif
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.opsel = '0; bus.mode = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    tick; tick;
    rst = 1'b0;
    chk("reset/req_ready", DATA_W'(bus.req_ready), DATA_W'(1));
    chk("reset/rsp_valid", DATA_W'(bus.rsp_valid), '0);
    chk("reset/result", bus.result, '0);
    chk("reset/flags", flags(), '0);

    // flags encoded {c,z,s,o}
    run_op("add_wrap",   1'b0, 3'd0, 1'b0, ONES, 128'd1, '0, 4'b1100, 1'b1);
    run_op("add_ovf",    1'b0, 3'd0, 1'b0, MAXP, 128'd1, MSB, 4'b0011, 1'b1);
    run_op("add_slice",  1'b0, 3'd0, 1'b0, 128'hFFFF_FFFF, 128'd1, 128'h1_0000_0000, 4'b0000, 1'b1);
    run_op("sub_neg",    1'b0, 3'd2, 1'b1, 128'd5, 128'd7, ONES - 128'd1, 4'b0010, 1'b1);
    run_op("sbb_eq",     1'b0, 3'd3, 1'b0, 128'd5, 128'd5, ONES, 4'b0010, 1'b1);
    run_op("adc_cin",    1'b0, 3'd1, 1'b1, 128'd1, 128'd2, 128'd4, 4'b0000, 1'b1);
    run_op("dec_zero",   1'b0, 3'd5, 1'b0, '0, 128'd123, ONES, 4'b0010, 1'b1);
    run_op("passb",      1'b0, 3'd7, 1'b1, ONES, MSB, MSB, 4'b0010, 1'b1);
    run_op("passa",      1'b0, 3'd6, 1'b1, ONES, 128'd5, ONES, 4'b0010, 1'b1);
    run_op("nand",       1'b1, 3'd4, 1'b0, '0, '0, ONES, 4'b0010, 1'b1);
    run_op("or",         1'b1, 3'd1, 1'b0, 128'h0F, 128'hF0, 128'hFF, 4'b0000, 1'b1);

    // Response stall: outputs frozen while writeback holds off
    run_op("xor", 1'b1, 3'd2, 1'b0, {16{8'hA5}}, {16{8'hA5}}, '0, 4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall/rsp_valid", DATA_W'(bus.rsp_valid), DATA_W'(1));
      chk("stall/req_ready", DATA_W'(bus.req_ready), '0);
      chk("stall/result", bus.result, '0);
      chk("stall/flags", flags(), DATA_W'(4'b0100));
    end
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
    chk("stall/release", DATA_W'({bus.rsp_valid, bus.req_ready}), DATA_W'(2'b01));

    // Abort mid-op with reset
    bus.mode = 1'b0; bus.opsel = 3'd0; bus.a = ONES; bus.b = ONES; bus.req_valid = 1'b1;
    tick;
    bus.req_valid = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort/req_ready", DATA_W'(bus.req_ready), DATA_W'(1));
    chk("abort/rsp_valid", DATA_W'(bus.rsp_valid), '0);
    chk("abort/result", bus.result, '0);
    chk("abort/flags", flags(), '0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (bus.rsp_valid) cnt++;
    end
    chk("abort/no_rsp", DATA_W'(cnt), '0);
    run_op("inc_zero", 1'b0, 3'd4, 1'b0, '0, ONES, 128'd1, 4'b0000, 1'b1);

    // Sustained requests with response always accepted
    bus.mode = 1'b0; bus.opsel = 3'd0; bus.cin = 1'b0; bus.a = 128'd1; bus.b = 128'd2;
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1;
    cnt = 0;
    while (!bus.rsp_valid && cnt < 20) begin
      tick;
      cnt++;
    end
    chk("b2b/first", DATA_W'(bus.rsp_valid), DATA_W'(1));
    for (int k = 0; k < 2; k++) begin
      cnt = 0;
      do begin
        tick;
        cnt++;
      end while (!bus.rsp_valid && cnt < 20);
      chk("b2b/period", DATA_W'(cnt), DATA_W'(per_exp));
      chk("b2b/result", bus.result, 128'd3);
    end
    bus.req_valid = 1'b0;
    tick;
    bus.rsp_ready = 1'b0;
    tick;
    chk("b2b/idle", DATA_W'({bus.rsp_valid, bus.req_ready}), DATA_W'(2'b01));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
